// File: rtl/tick_mon_pkg.sv
// Shared types and helpers for the divided-strobe period monitor.
package tick_mon_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StAcq,
    StLocked
  } state_e;

  // Divider reload value used by the default build; expected period is one more.
  localparam int unsigned DEF_CLK_DIV_VAL = 11;
  localparam int unsigned EXP_PERIOD      = DEF_CLK_DIV_VAL + 1;

  // Expected tick spacing for a given divider reload value.
  function automatic int unsigned exp_period(input int unsigned clk_div_val);
    return clk_div_val + 1;
  endfunction

  // True when |p - exp_p| <= tol; done on 32-bit values so no wrap at CNT_W.
  function automatic logic period_match(input int unsigned p,
                                        input int unsigned exp_p,
                                        input int unsigned tol);
    if (p >= exp_p) begin
      return (p - exp_p) <= tol;
    end
    return (exp_p - p) <= tol;
  endfunction

endpackage

// File: rtl/tick_period_monitor_if.sv
// Strobe-in / measurement-out bundle between a strobe source and the monitor.
interface tick_period_monitor_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             enable;
  logic             tick_in;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             period_err;

  // Source side: drives enable and the strobe, observes the results.
  modport master (
    output enable,
    output tick_in,
    input  period_out,
    input  period_valid,
    input  locked,
    input  period_err
  );

  // Monitor side.
  modport slave (
    input  enable,
    input  tick_in,
    output period_out,
    output period_valid,
    output locked,
    output period_err
  );

endinterface

// File: rtl/tick_interval_counter.sv
// Saturating count of cycles since the last clear.
module tick_interval_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  output logic [CNT_W-1:0] ivl
);

  logic [CNT_W-1:0] ivl_q;

  // Count up, hold at all-ones, synchronous clear has priority.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      ivl_q <= '0;
    end else if (clr) begin
      ivl_q <= '0;
    end else if (ivl_q != '1) begin
      ivl_q <= ivl_q + CNT_W'(1);
    end
  end

  assign ivl = ivl_q;

endmodule

// File: rtl/tick_period_monitor.sv
// Measures tick spacing of a divided strobe, tracks lock and flags bad/missing ticks.
module tick_period_monitor
  import tick_mon_pkg::*;
#(
  parameter int unsigned CLK_DIV_VAL = EXP_PERIOD - 1,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned TOL         = 0
) (
  input logic                 clk,
  input logic                 rstn,
  tick_period_monitor_if.slave mon
);

  localparam int unsigned      ExpPeriod  = exp_period(CLK_DIV_VAL);
  // First ivl value at which an on-time tick is no longer possible.
  localparam logic [CNT_W-1:0] TimeoutIvl = CNT_W'(CLK_DIV_VAL + 1 + TOL);
  localparam logic [3:0]       LockLast   = 4'(LOCK_CNT - 1);

  state_e           state_q, state_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] period_out_q, period_out_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q, locked_d;
  logic             period_err_q, period_err_d;

  logic [CNT_W-1:0] ivl;
  logic [CNT_W-1:0] period;
  logic             match;
  logic             ivl_clr;

  // Interval restarts on each tick and is held at zero while idle or disabled.
  assign ivl_clr = (state_q == StIdle) || !mon.enable || mon.tick_in;

  tick_interval_counter #(
    .CNT_W(CNT_W)
  ) u_ivl (
    .clk (clk),
    .rstn(rstn),
    .clr (ivl_clr),
    .ivl (ivl)
  );

  // Measured period is ivl+1, pinned at all-ones; the pinned value never matches.
  always_comb begin
    period = (ivl == '1) ? ivl : ivl + CNT_W'(1);
    match  = (period != '1) && period_match(32'(period), ExpPeriod, TOL);
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d        = state_q;
    match_cnt_d    = match_cnt_q;
    period_out_d   = period_out_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    period_err_d   = 1'b0;

    if (!mon.enable) begin
      // Disabled: drop to idle, keep the last measurement visible.
      state_d     = StIdle;
      match_cnt_d = '0;
      locked_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d     = StSync;
          match_cnt_d = '0;
        end
        StSync: begin
          // First tick only anchors the interval.
          if (mon.tick_in) begin
            state_d = StAcq;
          end
        end
        StAcq: begin
          if (mon.tick_in) begin
            period_out_d   = period;
            period_valid_d = 1'b1;
            if (!match) begin
              match_cnt_d = '0;
            end else if (match_cnt_q == LockLast) begin
              state_d     = StLocked;
              locked_d    = 1'b1;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + 4'd1;
            end
          end
        end
        StLocked: begin
          if (mon.tick_in) begin
            // A tick in the timeout cycle is measured like any other tick.
            period_out_d   = period;
            period_valid_d = 1'b1;
            if (!match) begin
              period_err_d = 1'b1;
              locked_d     = 1'b0;
              match_cnt_d  = '0;
              state_d      = StAcq;
            end
          end else if (ivl == TimeoutIvl) begin
            period_err_d = 1'b1;
            locked_d     = 1'b0;
            match_cnt_d  = '0;
            state_d      = StSync;
          end
        end
        default: begin
          state_d     = StIdle;
          match_cnt_d = '0;
          locked_d    = 1'b0;
        end
      endcase
    end
  end

  // State, lock counter and output registers.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q        <= StIdle;
      match_cnt_q    <= '0;
      period_out_q   <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      period_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      match_cnt_q    <= match_cnt_d;
      period_out_q   <= period_out_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      period_err_q   <= period_err_d;
    end
  end

  assign mon.period_out   = period_out_q;
  assign mon.period_valid = period_valid_q;
  assign mon.locked       = locked_q;
  assign mon.period_err   = period_err_q;

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed, table-driven bench for tick_period_monitor (TOL=0 and TOL=1 builds).
module tb_tick_period_monitor;

  localparam int unsigned CntW = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic en   = 1'b0;
  logic tick = 1'b0;
  logic sel_b = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  tick_period_monitor_if #(.CNT_W(CntW)) bus_a ();
  tick_period_monitor_if #(.CNT_W(CntW)) bus_b ();

  assign bus_a.enable  = en;
  assign bus_a.tick_in = tick;
  assign bus_b.enable  = en;
  assign bus_b.tick_in = tick;

  tick_period_monitor #(
    .CLK_DIV_VAL(11),
    .CNT_W      (CntW),
    .LOCK_CNT   (4),
    .TOL        (0)
  ) dut_a (
    .clk (clk),
    .rstn(rstn),
    .mon (bus_a)
  );

  tick_period_monitor #(
    .CLK_DIV_VAL(11),
    .CNT_W      (CntW),
    .LOCK_CNT   (4),
    .TOL        (1)
  ) dut_b (
    .clk (clk),
    .rstn(rstn),
    .mon (bus_b)
  );

  always #5 clk = ~clk;

  // Outputs of whichever instance is under test.
  logic [CntW-1:0] o_period;
  logic            o_valid, o_locked, o_err;
  always_comb begin
    o_period = sel_b ? bus_b.period_out   : bus_a.period_out;
    o_valid  = sel_b ? bus_b.period_valid : bus_a.period_valid;
    o_locked = sel_b ? bus_b.locked       : bus_a.locked;
    o_err    = sel_b ? bus_b.period_err   : bus_a.period_err;
  end

  // gap = idle cycles before the tick, so the tick's measured period is gap+1.
  typedef struct {
    int unsigned gap;
    logic        en;
    logic        exp_valid;
    int unsigned exp_period;
    logic        exp_locked;
    logic        exp_err;
  } vec_t;

  vec_t tbl_b[$];
  vec_t tbl_a[$];
  vec_t tbl_c[$];

  function automatic vec_t mk(input int unsigned gap, input logic e, input logic v,
                              input int unsigned p, input logic l, input logic er);
    vec_t r;
    r.gap        = gap;
    r.en         = e;
    r.exp_valid  = v;
    r.exp_period = p;
    r.exp_locked = l;
    r.exp_err    = er;
    return r;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic cyc(input logic e, input logic t);
    en   = e;
    tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input int idx, input vec_t v);
    for (int i = 0; i < int'(v.gap); i++) begin
      cyc(1'b1, 1'b0);
      chk($sformatf("%s%0d quiet", tag, idx), {30'd0, o_valid, o_err}, 0);
    end
    cyc(v.en, 1'b1);
    chk($sformatf("%s%0d valid", tag, idx), 32'(o_valid), 32'(v.exp_valid));
    if (v.exp_valid) begin
      chk($sformatf("%s%0d period", tag, idx), 32'(o_period), v.exp_period);
    end
    chk($sformatf("%s%0d locked", tag, idx), 32'(o_locked), 32'(v.exp_locked));
    chk($sformatf("%s%0d err", tag, idx), 32'(o_err), 32'(v.exp_err));
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    en   = 1'b0;
    tick = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b0;
  endtask

  initial begin
    // TOL=1: periods 11,13,12,11 lock; 14 lands on the timeout cycle and errors.
    tbl_b.push_back(mk(1,  1'b1, 1'b0, 0,  1'b0, 1'b0));
    tbl_b.push_back(mk(10, 1'b1, 1'b1, 11, 1'b0, 1'b0));
    tbl_b.push_back(mk(12, 1'b1, 1'b1, 13, 1'b0, 1'b0));
    tbl_b.push_back(mk(11, 1'b1, 1'b1, 12, 1'b0, 1'b0));
    tbl_b.push_back(mk(10, 1'b1, 1'b1, 11, 1'b1, 1'b0));
    tbl_b.push_back(mk(13, 1'b1, 1'b1, 14, 1'b0, 1'b1));

    // TOL=0: acquire, lock, late tick, relock, back-to-back tick, relock.
    tbl_a.push_back(mk(1,  1'b1, 1'b0, 0,  1'b0, 1'b0));
    for (int i = 0; i < 4; i++) tbl_a.push_back(mk(11, 1'b1, 1'b1, 12, (i == 3), 1'b0));
    tbl_a.push_back(mk(12, 1'b1, 1'b1, 13, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++) tbl_a.push_back(mk(11, 1'b1, 1'b1, 12, (i == 3), 1'b0));
    tbl_a.push_back(mk(0,  1'b1, 1'b1, 1,  1'b0, 1'b1));
    for (int i = 0; i < 4; i++) tbl_a.push_back(mk(11, 1'b1, 1'b1, 12, (i == 3), 1'b0));
    tbl_a.push_back(mk(11, 1'b1, 1'b1, 12, 1'b1, 1'b0));

    // After timeout (SYNC): anchor tick, 2 matches, saturated period, lock, disable.
    tbl_c.push_back(mk(3,   1'b1, 1'b0, 0,   1'b0, 1'b0));
    tbl_c.push_back(mk(11,  1'b1, 1'b1, 12,  1'b0, 1'b0));
    tbl_c.push_back(mk(11,  1'b1, 1'b1, 12,  1'b0, 1'b0));
    tbl_c.push_back(mk(299, 1'b1, 1'b1, 255, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) tbl_c.push_back(mk(11, 1'b1, 1'b1, 12, (i == 3), 1'b0));
    tbl_c.push_back(mk(11,  1'b0, 1'b0, 0,   1'b0, 1'b0));

    do_reset();
    chk("rst period", 32'(o_period), 0);
    chk("rst valid", 32'(o_valid), 0);
    chk("rst locked", 32'(o_locked), 0);
    chk("rst err", 32'(o_err), 0);

    sel_b = 1'b1;
    cyc(1'b1, 1'b0);
    foreach (tbl_b[i]) run_vec("b", i, tbl_b[i]);

    do_reset();
    sel_b = 1'b0;
    cyc(1'b1, 1'b0);
    foreach (tbl_a[i]) run_vec("a", i, tbl_a[i]);

    // Ticks stop while locked: one error when ivl reaches the timeout value.
    for (int k = 1; k <= 30; k++) begin
      cyc(1'b1, 1'b0);
      chk($sformatf("timeout k%0d", k), {30'd0, o_valid, o_err}, (k == 13) ? 1 : 0);
      if (k == 12) chk("timeout pre-lock", 32'(o_locked), 1);
      if (k == 13) chk("timeout unlock", 32'(o_locked), 0);
    end

    foreach (tbl_c[i]) run_vec("c", i, tbl_c[i]);
    chk("disable hold period", 32'(o_period), 12);

    // Tick in the re-enable cycle lands in IDLE and must be ignored.
    run_vec("d", 0, mk(0,  1'b1, 1'b0, 0,  1'b0, 1'b0));
    run_vec("d", 1, mk(1,  1'b1, 1'b0, 0,  1'b0, 1'b0));
    for (int i = 0; i < 4; i++) run_vec("d", 2 + i, mk(11, 1'b1, 1'b1, 12, (i == 3), 1'b0));

    // Asynchronous reset while locked clears outputs before the next edge.
    #2;
    rstn = 1'b1;
    #1;
    chk("async rst period", 32'(o_period), 0);
    chk("async rst locked", 32'(o_locked), 0);
    chk("async rst valid", 32'(o_valid), 0);
    chk("async rst err", 32'(o_err), 0);
    #1;
    rstn = 1'b0;
    cyc(1'b1, 1'b1);
    chk("post rst valid", 32'(o_valid), 0);
    chk("post rst locked", 32'(o_locked), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
